fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter that shares one fifo_sync_top write port among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter_if.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ producers, the write arbiter and one FIFO write port.
// stall_cnt is present only when FIFO_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]                   stall_cnt;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, stall_cnt
  );
  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, stall_cnt
  );
`else
  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );
  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; FIFO_ARB_STATS_EN adds stall_cnt.
// One-cycle arbitration, zero-latency beat path; fifo_full stalls the granted producer.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         pick;
  logic [ID_W-1:0]         next_ptr;
  logic [7:0]              beat_cnt;
  logic                    busy;
  logic                    found;
  logic                    valid_g;
  logic                    last_g;
  logic                    accept;
  logic                    rel;
  logic [2*NUM_REQ-1:0]    dbl;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic [NUM_REQ-1:0]      ready;
  int                      sum;

  // Rotate the request vector so bit 0 is rr_ptr; the first set bit wins.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    sum   = 0;
    dbl   = {bus.req_valid, bus.req_valid} >> rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + k;
        pick  = ID_W'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    valid_g  = bus.req_valid[grant_id];
    last_g   = bus.req_last[grant_id];
    accept   = (state == GRANT) && valid_g && !bus.fifo_full;
    rel      = (state == GRANT) &&
               ((accept && (last_g || beat_cnt == 8'(BURST_LEN - 1))) ||
                (!valid_g && !bus.fifo_full));
    next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    ready    = '0;
    if (state == GRANT) ready[grant_id] = !bus.fifo_full;
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_data_in = data_sel;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          if (rel) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
    end else if (state == GRANT && valid_g && bus.fifo_full && bus.stall_cnt != 16'hFFFF) begin
      bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queued producers, FIFO-write scoreboard and monitor.
module tb_fifo_wr_arbiter;
  typedef struct packed { logic [7:0] d; logic last; } beat_t;
  typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;

  logic  clk;
  logic  rst;
  beat_t pq [4][$];
  exp_t  sb [$];
  int    checks = 0;
  int    errors = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic last);
    beat_t b;
    b.d    = d;
    b.last = last;
    pq[r].push_back(b);
  endtask

  task automatic expect_wr(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      done = !bus.busy && (bus.req_valid == 4'b0) && (sb.size() == 0);
    end
    chk({name, "_idle"}, int'(done), 1);
  endtask

  task automatic wait_writes(input string name, input int n);
    int cyc = 0;
    int seen = 0;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_wr_en) seen++;
    end
    chk({name, "_writes"}, seen, n);
  endtask

  // Producers: present the queue head, pop it once the handshake is seen.
  initial begin : producers
    logic [3:0] fired;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      fired = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (fired[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[i*8 +: 8]  = pq[i][0].d;
          bus.req_last[i]         = pq[i][0].last;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (bus.fifo_wr_en === 1'b1 && bus.fifo_full === 1'b1) begin
        errors++;
        $display("FAIL wr_while_full: wr_en=%b full=%b, required wr_en=0", bus.fifo_wr_en, bus.fifo_full);
      end
      if (bus.fifo_wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: id=%0d data=%h, required no write", bus.grant_id, bus.fifo_data_in);
        end else begin
          e = sb.pop_front();
          if (bus.fifo_data_in !== e.d || bus.grant_id !== e.id) begin
            errors++;
            $display("FAIL fifo_write: id=%0d data=%h, expected id=%0d data=%h",
                     bus.grant_id, bus.fifo_data_in, e.id, e.d);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int first;
    int last_w;
    int nw;
    int cyc;
    rst           = 1'b1;
    bus.fifo_full = 1'b0;

    // Reset with all four requesters valid, one beat each.
    for (int i = 0; i < 4; i++) begin
      push_beat(i, 8'hA0 + 8'(i), 1'b1);
      expect_wr(2'(i), 8'hA0 + 8'(i));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_in", int'(bus.req_valid), 4'hF);
    chk("reset_outputs", int'({bus.busy, bus.grant_id, bus.fifo_wr_en, bus.req_ready}), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("reset_stall_cnt", int'(bus.stall_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    wait_idle("t1");

    // Round robin: four requesters, no last, BURST_LEN caps every burst.
    tick();
    for (int b = 0; b < 8; b++) push_beat(0, 8'h00 + 8'(b), 1'b0);
    for (int i = 1; i < 4; i++)
      for (int b = 0; b < 4; b++) push_beat(i, 8'(i * 16 + b), 1'b0);
    for (int b = 0; b < 4; b++) expect_wr(2'd0, 8'h00 + 8'(b));
    for (int i = 1; i < 4; i++)
      for (int b = 0; b < 4; b++) expect_wr(2'(i), 8'(i * 16 + b));
    for (int b = 4; b < 8; b++) expect_wr(2'd0, 8'h00 + 8'(b));
    first = -1; last_w = 0; nw = 0; cyc = 0;
    while (nw < 20 && cyc < 300) begin
      @(negedge clk);
      if (bus.fifo_wr_en) begin
        if (first < 0) first = cyc;
        last_w = cyc;
        nw++;
      end
      cyc++;
    end
    chk("rr_write_count", nw, 20);
    chk("rr_span_cycles", last_w - first, 23);
    wait_idle("t3");

    // Single requester: 3 beats ending with last.
    tick();
    push_beat(1, 8'h11, 1'b0);
    push_beat(1, 8'h22, 1'b0);
    push_beat(1, 8'h33, 1'b1);
    expect_wr(2'd1, 8'h11);
    expect_wr(2'd1, 8'h22);
    expect_wr(2'd1, 8'h33);
    @(negedge clk);
    chk("arb_latency_busy0", int'(bus.busy), 0);
    @(negedge clk);
    chk("single_grant", int'({bus.busy, bus.grant_id}), 3'b101);
    wait_idle("t2");

    // rr_ptr now 2: req0 and req2 together -> req2 first.
    tick();
    push_beat(0, 8'h01, 1'b1);
    push_beat(2, 8'h02, 1'b1);
    expect_wr(2'd2, 8'h02);
    expect_wr(2'd0, 8'h01);
    wait_idle("t2b");

    // Full stall of 5 cycles in the middle of a req2 burst.
    tick();
    for (int b = 0; b < 4; b++) begin
      push_beat(2, 8'hC0 + 8'(b), 1'b0);
      expect_wr(2'd2, 8'hC0 + 8'(b));
    end
    wait_writes("stall_pre", 2);
    tick();
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_hold", int'({bus.busy, bus.grant_id, bus.fifo_wr_en, bus.req_ready}), 8'hC0);
    end
    tick();
    bus.fifo_full = 1'b0;
    wait_idle("t4");
`ifdef FIFO_ARB_STATS_EN
    chk("stall_cnt", int'(bus.stall_cnt), 5);
`endif

    // Wrap: req3 granted, then req0 and req3 contend -> req0 wins.
    tick();
    push_beat(3, 8'h35, 1'b1);
    expect_wr(2'd3, 8'h35);
    wait_writes("wrap_first", 1);
    tick();
    push_beat(0, 8'h05, 1'b1);
    push_beat(3, 8'h36, 1'b1);
    expect_wr(2'd0, 8'h05);
    expect_wr(2'd3, 8'h36);
    wait_idle("t5");

    // Move rr_ptr to 3, then reset in the middle of a req1 burst.
    tick();
    push_beat(2, 8'h52, 1'b1);
    expect_wr(2'd2, 8'h52);
    wait_idle("t6_pre");
    tick();
    push_beat(1, 8'h61, 1'b0);
    push_beat(1, 8'h62, 1'b0);
    push_beat(1, 8'h63, 1'b1);
    expect_wr(2'd1, 8'h61);
    wait_writes("mid_rst_pre", 1);
    tick();
    rst           = 1'b1;
    bus.fifo_full = 1'b1;
    push_beat(3, 8'h73, 1'b1);
    @(negedge clk);
    tick();
    rst           = 1'b0;
    bus.fifo_full = 1'b0;
    expect_wr(2'd1, 8'h62);
    expect_wr(2'd1, 8'h63);
    expect_wr(2'd3, 8'h73);
    @(negedge clk);
    chk("mid_rst_idle", int'({bus.busy, bus.grant_id, bus.fifo_wr_en, bus.req_ready}), 0);
    @(negedge clk);
    chk("post_rst_grant", int'({bus.busy, bus.grant_id}), 3'b101);
    wait_idle("t6");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
